rr_port_arbiter: RTL and testbench
==================================

# rr_port_arbiter

Parametrised per-output-port switch arbiter for the router crossbar, successor to the fixed-priority output selectors. Picks one of N input ports requesting the same output, then holds the grant (wormhole lock) until the tail flit of the winning packet crosses. Round-robin or fixed-priority order, chosen by parameter. Drives the registered one-hot crossbar select for that output and a per-cycle transfer strobe for the input buffers.

## Interface
- N, 5: number of input ports competing for this output, 2..16.
- MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  req[i] = input i has a flit at its buffer head routed to this output.
- tail  input  N  tail[i] = the head flit of input i is a tail flit; qualified by req[i].
- credit_ok  input  1  downstream buffer can accept a flit this cycle.
- select  output  N  registered one-hot crossbar select; all-zero when idle.
- busy  output  1  registered; 1 while a packet holds the output.
- xfer  output  N  combinational; xfer[i] = select[i] & req[i] & credit_ok; the owner's flit moves this cycle.

## Operation
- State: busy (IDLE = 0, LOCKED = 1), owner-implied by select, ptr ($clog2(N) bits, next-highest-priority index).
- Arbitration function (combinational): over candidate vector c, MODE 0 returns the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N); MODE 1 returns the lowest set bit. ptr is ignored in MODE 1 but still updated.
- IDLE: if any req and credit_ok, grant winner w of c = req: select <= onehot(w), busy <= 1. Otherwise select stays 0. No grant when credit_ok = 0.
- LOCKED: select held constant. Transfer occurs when xfer is nonzero.
  - Transfer of non-tail flit: stay LOCKED.
  - Transfer of tail flit (xfer[o] & tail[o]): release. ptr <= (o+1) mod N. Same edge, re-arbitrate over c = req with the new ptr, masking req[o] (its current flit just left); if a winner exists and credit_ok, select <= onehot(w), stay LOCKED; else select <= 0, busy <= 0.
  - Owner deasserts req (buffer empty mid-packet): hold lock, no transfer; other requesters wait.
  - credit_ok = 0: hold lock, no transfer.
- Single-flit packet (head = tail): granted, then released on its transfer cycle.
- Output select is never X; all-zero represents no grant.
- Invariant: select is one-hot exactly when busy = 1, else all-zero.

## Timing
- Reset (async assert): select = 0, busy = 0, ptr = 0, xfer = 0 (follows select). Reset mid-packet drops the lock immediately; no flit counted.
- Grant latency: req seen at edge k (IDLE, credit_ok) -> select valid after edge k; first xfer possible in cycle k+1.
- Back-to-back packets: zero idle cycles between a tail transfer and the next owner's first possible transfer.
- xfer is purely combinational from registered select and current req/credit_ok; no other combinational path to outputs.
- Simultaneous requests at release: new winner is first requester after the released owner; released owner can win again only on a later arbitration.
- ptr wrap: owner N-1 -> ptr = 0.

## Test plan
- Reset/idle: rst pulsed mid-cycle with select = 00100 -> select = 00000, busy = 0 immediately; req = 0 afterwards -> select stays 00000.
- Single requester, 3-flit packet: req = 00010, credit_ok = 1, tail on third flit -> select = 00010 one cycle later, xfer[1] three cycles, then select = 00000, busy = 0, ptr = 2.
- Round-robin fairness (MODE 0): req = 11111 held, every packet single-flit -> grant order 0,1,2,3,4,0 with no idle cycle between grants.
- Fixed priority (MODE 1): req = 11010 held, single-flit packets -> owner 1 repeatedly re-wins after each idle-free gap only when req[1] re-presents; with req[1] masked on release, input 3 wins next, then 1.
- Stall handling: owner 2 locked, credit_ok = 0 for 4 cycles, then req[2] = 0 for 2 cycles while req[0] = 1 -> select stays 00100, xfer = 0, input 0 never granted until tail of input 2 transfers.
- Wrap and N=8, MODE 0: owner 7 releases with req = 10000001 -> ptr = 0, next select = 00000001.

Source files
------------

// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter
//   Per-output-port switch arbiter. Picks one of N requesting input ports,
//   then holds the grant (wormhole lock) until the winning packet's tail flit
//   crosses. Arbitration order is round-robin (MODE 0) or fixed priority with
//   the lowest index winning (MODE 1).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-input request for this output
//   tail       per-input "head flit is a tail flit", qualified by req
//   credit_ok  downstream can accept a flit this cycle
//   select     registered one-hot crossbar select, all-zero when idle
//   busy       registered, high while a packet holds the output
//   xfer       combinational per-input transfer strobe
module rr_port_arbiter #(
   parameter int unsigned N    = 5,
   parameter int unsigned MODE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] tail,
   input  logic         credit_ok,
   output logic [N-1:0] select,
   output logic         busy,
   output logic [N-1:0] xfer
);

   localparam int unsigned PtrW = $clog2(N);

   logic [N-1:0]    select_q, select_d;
   logic            busy_q, busy_d;
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] ptr_after_owner;
   logic            tail_xfer;

   // First set bit of c scanning from p upward with wrap (MODE 0), or the
   // lowest set bit (MODE 1). Returns one-hot, all-zero if c is empty.
   function automatic logic [N-1:0] arbitrate(input logic [N-1:0]    c,
                                              input logic [PtrW-1:0] p);
      logic [N-1:0] w;
      logic         found;
      int unsigned  idx;
      w     = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (MODE == 1) begin
            idx = k;
         end else begin
            idx = 32'(p) + k;
            if (idx >= N) idx = idx - N;
         end
         if (!found && c[idx]) begin
            w[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return w;
   endfunction

   assign xfer      = select_q & req & {N{credit_ok}};
   assign tail_xfer = |(xfer & tail);
   assign select    = select_q;
   assign busy      = busy_q;

   // Index just past the current owner, wrapping N-1 -> 0.
   always_comb begin
      ptr_after_owner = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (select_q[i]) ptr_after_owner = (i == N - 1) ? '0 : PtrW'(i + 1);
      end
   end

   always_comb begin
      logic [N-1:0] win;
      select_d = select_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      win      = '0;
      if (!busy_q) begin
         if ((|req) && credit_ok) begin
            select_d = arbitrate(req, ptr_q);
            busy_d   = 1'b1;
         end
      end else if (tail_xfer) begin
         ptr_d = ptr_after_owner;
         // The released owner's flit just left, so it cannot win this edge.
         win   = arbitrate(req & ~select_q, ptr_after_owner);
         if ((|win) && credit_ok) begin
            select_d = win;
         end else begin
            select_d = '0;
            busy_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         select_q <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
      end else begin
         select_q <= select_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
      end
   end

endmodule

// File: tb/tb_rr_port_arbiter.sv
module tb_rr_port_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] req5 = '0, tail5 = '0;
   logic [7:0] req8 = '0, tail8 = '0;
   logic       credit_ok = 1'b0;

   logic [4:0] sel_rr5, xfer_rr5, sel_fp5, xfer_fp5;
   logic [7:0] sel_rr8, xfer_rr8;
   logic       busy_rr5, busy_fp5, busy_rr8;

   int errors = 0;
   int checks = 0;

   // Reference state per instance: owner index (-1 = idle) and pointer.
   int nport [3] = '{5, 5, 8};
   int mode  [3] = '{0, 1, 0};
   int own   [3];
   int ptr   [3];

   always #5 clk = ~clk;

   rr_port_arbiter #(.N(5), .MODE(0)) u_rr5 (
      .clk(clk), .rst(rst), .req(req5), .tail(tail5), .credit_ok(credit_ok),
      .select(sel_rr5), .busy(busy_rr5), .xfer(xfer_rr5));

   rr_port_arbiter #(.N(5), .MODE(1)) u_fp5 (
      .clk(clk), .rst(rst), .req(req5), .tail(tail5), .credit_ok(credit_ok),
      .select(sel_fp5), .busy(busy_fp5), .xfer(xfer_fp5));

   rr_port_arbiter #(.N(8), .MODE(0)) u_rr8 (
      .clk(clk), .rst(rst), .req(req8), .tail(tail8), .credit_ok(credit_ok),
      .select(sel_rr8), .busy(busy_rr8), .xfer(xfer_rr8));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int arb_model(input int id, input logic [15:0] c, input int p);
      int i;
      for (int k = 0; k < nport[id]; k++) begin
         i = (mode[id] == 1) ? k : (p + k) % nport[id];
         if (c[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [15:0] model_sel(input int id);
      return (own[id] >= 0) ? (16'd1 << own[id]) : 16'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         own[i] = -1;
         ptr[i] = 0;
      end
   endtask

   task automatic model_step(input int id, input logic [15:0] r, input logic [15:0] t,
                             input logic cr);
      logic [15:0] c;
      int          w;
      if (own[id] < 0) begin
         if (r != 0 && cr) own[id] = arb_model(id, r, ptr[id]);
      end else if (r[own[id]] && cr && t[own[id]]) begin
         ptr[id] = (own[id] + 1) % nport[id];
         c = r;
         c[own[id]] = 1'b0;
         w = arb_model(id, c, ptr[id]);
         own[id] = (w >= 0 && cr) ? w : -1;
      end
   endtask

   task automatic check_inst(input int id, input string tag, input logic [15:0] sel,
                             input logic bsy, input logic [15:0] xf, input logic [15:0] r);
      logic [15:0] es;
      es = model_sel(id);
      check_eq({tag, ".select"}, 32'(sel), 32'(es));
      check_eq({tag, ".busy"}, 32'(bsy), 32'(own[id] >= 0));
      check_eq({tag, ".xfer"}, 32'(xf), 32'(es & r & {16{credit_ok}}));
   endtask

   task automatic check_all();
      check_inst(0, "rr5", 16'(sel_rr5), busy_rr5, 16'(xfer_rr5), 16'(req5));
      check_inst(1, "fp5", 16'(sel_fp5), busy_fp5, 16'(xfer_fp5), 16'(req5));
      check_inst(2, "rr8", 16'(sel_rr8), busy_rr8, 16'(xfer_rr8), 16'(req8));
   endtask

   // Called at posedge+1: drive inputs, compare at negedge, optionally pulse
   // an asynchronous reset mid-cycle, advance the model, move to next edge.
   task automatic cycle(input logic [4:0] r5, input logic [4:0] t5, input logic [7:0] r8,
                        input logic [7:0] t8, input logic cr, input bit pulse_rst);
      req5 = r5; tail5 = t5; req8 = r8; tail8 = t8; credit_ok = cr;
      @(negedge clk);
      check_all();
      if (pulse_rst) begin
         rst = 1'b1;
         #1;
         check_eq("midrst.select", 32'({sel_rr5, sel_fp5, sel_rr8}), 32'd0);
         check_eq("midrst.busy", 32'({busy_rr5, busy_fp5, busy_rr8}), 32'd0);
         check_eq("midrst.xfer", 32'({xfer_rr5, xfer_fp5, xfer_rr8}), 32'd0);
         rst = 1'b0;
         model_reset();
      end
      model_step(0, 16'(r5), 16'(t5), cr);
      model_step(1, 16'(r5), 16'(t5), cr);
      model_step(2, 16'(r8), 16'(t8), cr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      #3;
      check_eq("reset.select", 32'({sel_rr5, sel_fp5, sel_rr8}), 32'd0);
      check_eq("reset.busy", 32'({busy_rr5, busy_fp5, busy_rr8}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle with no requests stays idle.
      cycle(5'b0, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("idle.select", 32'(sel_rr5), 32'd0);

      // Single requester, 3-flit packet; pointer lands on 2 afterwards.
      cycle(5'b00010, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("pkt3.grant", 32'(sel_rr5), 32'b00010);
      cycle(5'b00010, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      cycle(5'b00010, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      cycle(5'b00010, 5'b00010, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("pkt3.release", 32'({sel_rr5, busy_rr5}), 32'd0);
      cycle(5'b00011, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("pkt3.ptr2_picks0", 32'(sel_rr5), 32'b00001);
      check_eq("pkt3.fp_picks0", 32'(sel_fp5), 32'b00001);

      // Round-robin fairness, all requesting, single-flit packets.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle(5'b11111, 5'b11111, 8'b0, 8'b0, 1'b1, 1'b0);
         check_eq($sformatf("rr.grant%0d", k), 32'(sel_rr5), 32'(5'b1 << (k % 5)));
         check_eq($sformatf("rr.busy%0d", k), 32'(busy_rr5), 32'd1);
      end

      // Fixed priority with req[1] masked on release: 1, then 3, then 1.
      do_reset();
      cycle(5'b11010, 5'b11010, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("fp.first", 32'(sel_fp5), 32'b00010);
      cycle(5'b11010, 5'b11010, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("fp.second", 32'(sel_fp5), 32'b01000);
      cycle(5'b11010, 5'b11010, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("fp.third", 32'(sel_fp5), 32'b00010);

      // Stall: owner 2 under no credit, then empty buffer; input 0 waits.
      do_reset();
      cycle(5'b00100, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cycle(5'b00101, 5'b00100, 8'b0, 8'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) cycle(5'b00001, 5'b0, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("stall.hold", 32'(sel_rr5), 32'b00100);
      cycle(5'b00101, 5'b00100, 8'b0, 8'b0, 1'b1, 1'b0);
      check_eq("stall.next", 32'(sel_rr5), 32'b00001);

      // Wrap on N=8: owner 7 releases, pointer wraps to 0.
      do_reset();
      cycle(5'b0, 5'b0, 8'b10000000, 8'b0, 1'b1, 1'b0);
      check_eq("wrap.own7", 32'(sel_rr8), 32'h80);
      cycle(5'b0, 5'b0, 8'b10000001, 8'b10000001, 1'b1, 1'b0);
      check_eq("wrap.next0", 32'(sel_rr8), 32'h01);

      // Random traffic against the model, with occasional mid-cycle resets.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         logic [4:0] r5, t5;
         logic [7:0] r8, t8;
         for (int b = 0; b < 8; b++) begin
            r8[b] = ($urandom_range(0, 9) < 6);
            t8[b] = ($urandom_range(0, 9) < 3);
         end
         r5 = r8[4:0];
         t5 = t8[4:0];
         cycle(r5, t5, r8, t8, ($urandom_range(0, 9) < 8), ($urandom_range(0, 199) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
